// File: rtl/regfile_write_arbiter.sv
// Purpose : shares the register file write port between requesters A and B; clears every register after reset.
// Latency : one cycle from an accepted handshake to RegWrite/WriteReg/WriteData.
// Backpr. : round-robin grant. No ready is given while reset or the clear walk is active. Requests are held, never dropped.
// Option  : define REG0_PROTECT_EN to suppress requester writes to register 0 (the clear walk still writes it).
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              busy
);

`ifdef REG0_PROTECT_EN
    localparam bit PROTECT_REG0 = 1'b1;
`else
    localparam bit PROTECT_REG0 = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_ARB   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    // rr_q = 1 means B was granted last, so A wins the next contention
    logic                rr_q, rr_d;
    logic                regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]   writereg_q, writereg_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;
    logic                grant_a, grant_b;

    // State and output registers; reset restarts the clear walk and discards any in-flight write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            rr_q        <= 1'b1;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    // Next state, clear counter, round-robin pointer and the registered write command
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        unique case (state_q)
            S_CLEAR: begin
                regwrite_d  = 1'b1;
                writereg_d  = cnt_q;
                writedata_d = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_REG) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (grant_a) begin
                    regwrite_d  = !(PROTECT_REG0 && (a_reg == '0));
                    writereg_d  = a_reg;
                    writedata_d = a_data;
                    rr_d        = 1'b0;
                end else if (grant_b) begin
                    regwrite_d  = !(PROTECT_REG0 && (b_reg == '0));
                    writereg_d  = b_reg;
                    writedata_d = b_data;
                    rr_d        = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Grants and handshake outputs; a lone requester always wins, contention alternates
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if ((state_q == S_ARB) && !rst) begin
            grant_a = a_valid && (!b_valid || rr_q);
            grant_b = b_valid && (!a_valid || !rr_q);
        end
        a_ready = grant_a;
        b_ready = grant_b;
        busy    = (state_q == S_CLEAR);
    end

    assign RegWrite  = regwrite_q;
    assign WriteReg  = writereg_q;
    assign WriteData = writedata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: expected write commands are queued when a grant
// is predicted and compared one cycle later when the DUT drives the register file port.
// Honours REG0_PROTECT_EN the same way as the design.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef REG0_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_reg, b_reg;
    logic [DW-1:0] a_data, b_data;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          busy;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .busy(busy)
    );

    typedef struct {
        logic          vld;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    logic   mon_en   = 1'b0;
    logic   m_rr     = 1'b1;   // model pointer: 1 = B granted last

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: each queued entry is the expected write port state one cycle after its request cycle
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (RegWrite !== e.vld || (e.vld && (WriteReg !== e.r || WriteData !== e.d)))
                $display("FAIL wr_port t=%0t: got RegWrite=%b WriteReg=%0d WriteData=%h, want RegWrite=%b WriteReg=%0d WriteData=%h",
                         $time, RegWrite, WriteReg, WriteData, e.vld, e.r, e.d);
            else
                n_pass++;
        end
    end

    // One arbitration cycle: drive requests, check readies against the model, queue the expected write
    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                         input string tag);
        logic ga, gb;
        exp_t it;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        ga = av && (!bv || m_rr);
        gb = bv && (!av || !m_rr);
        @(negedge clk);
        n_checks++;
        if (a_ready !== ga || b_ready !== gb)
            $display("FAIL %s ready t=%0t: got a_ready=%b b_ready=%b, want %b %b", tag, $time, a_ready, b_ready, ga, gb);
        else
            n_pass++;
        it.vld = 1'b0; it.r = '0; it.d = '0;
        if (ga) begin
            it.vld = !(PROT && ar == '0); it.r = ar; it.d = ad; m_rr = 1'b0;
        end else if (gb) begin
            it.vld = !(PROT && br == '0); it.r = br; it.d = bd; m_rr = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(it);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, '0, '0, 1'b0, '0, '0, tag);
    endtask

    task automatic test_reset_clear();
        exp_t it;
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || RegWrite !== 1'b0 || WriteReg !== '0 || WriteData !== '0 || a_ready !== 1'b0 || b_ready !== 1'b0)
            $display("FAIL reset_state: got busy=%b RegWrite=%b WriteReg=%0d WriteData=%h a_ready=%b b_ready=%b, want 1 0 0 0 0 0",
                     busy, RegWrite, WriteReg, WriteData, a_ready, b_ready);
        else
            n_pass++;
        rst = 1'b0;
        for (int k = 0; k < NR - 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (RegWrite !== 1'b1 || WriteReg !== AW'(k) || WriteData !== '0 || busy !== 1'b1 || a_ready !== 1'b0)
                $display("FAIL clear_step: got RegWrite=%b WriteReg=%0d WriteData=%h busy=%b a_ready=%b, want 1 %0d 0 1 0",
                         RegWrite, WriteReg, WriteData, busy, a_ready, k);
            else
                n_pass++;
        end
        // Final clear write: busy has dropped and the held A request is now accepted
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== AW'(NR - 1) || busy !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0)
            $display("FAIL clear_last: got RegWrite=%b WriteReg=%0d busy=%b a_ready=%b b_ready=%b, want 1 %0d 0 1 0",
                     RegWrite, WriteReg, busy, a_ready, b_ready, NR - 1);
        else
            n_pass++;
        m_rr = 1'b0;
        @(posedge clk);
        #1;
        it.vld = 1'b1; it.r = 5'd7; it.d = 32'h77;
        exp_q.push_back(it);
        a_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 5'd6, 32'd912, 1'b0, '0, '0, "single_a");
        idle("single_idle0");
        idle("single_idle1");
    endtask

    task automatic test_fairness();
        drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hB0B0, "fair_b_solo");
        drive(1'b1, 5'd13, 32'hA1, 1'b1, 5'd14, 32'hB1, "fair_both0");
        drive(1'b1, 5'd13, 32'hA1, 1'b1, 5'd14, 32'hB1, "fair_both1");
        idle("fair_idle");
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, "contend");
        drive(1'b1, 5'd20, 32'hDEAD_BEEF, 1'b0, '0, '0, "solo_a0");
        drive(1'b1, 5'd21, 32'hCAFE_F00D, 1'b0, '0, '0, "solo_a1");
        idle("contend_idle");
    endtask

    task automatic test_same_reg();
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, "same_reg0");
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, "same_reg1");
        idle("same_idle");
    endtask

    task automatic test_reg0();
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, "reg0_a");
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, "reg0_b");
        idle("reg0_idle");
    endtask

    task automatic test_reset_mid();
        exp_t it;
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
        b_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0)
            $display("FAIL rst_mid_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
        else
            n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_valid = 1'b0;
        m_rr = 1'b1;
        it.vld = 1'b0; it.r = '0; it.d = '0;
        exp_q.push_back(it);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL rst_mid_busy: got busy=%b, want 1", busy);
        else
            n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (RegWrite !== 1'b1 || WriteReg !== '0 || WriteData !== '0)
            $display("FAIL rst_mid_restart: got RegWrite=%b WriteReg=%0d WriteData=%h, want 1 0 0", RegWrite, WriteReg, WriteData);
        else
            n_pass++;
        repeat (NR - 1) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || RegWrite !== 1'b1 || WriteReg !== AW'(NR - 1))
            $display("FAIL rst_mid_done: got busy=%b RegWrite=%b WriteReg=%0d, want 0 1 %0d", busy, RegWrite, WriteReg, NR - 1);
        else
            n_pass++;
        mon_en = 1'b1;
        // Pointer is back to its reset value, so A must win the first contention
        drive(1'b1, 5'd17, 32'hA17, 1'b1, 5'd18, 32'hB18, "post_rst0");
        drive(1'b1, 5'd17, 32'hA17, 1'b1, 5'd18, 32'hB18, "post_rst1");
        idle("post_rst_idle");
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        test_reset_clear();
        test_single();
        test_fairness();
        test_contention();
        test_same_reg();
        test_reg0();
        test_reset_mid();
        idle("drain");
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d unchecked expected writes, want 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
